// File: rtl/ice51_top.sv
// ice51_top: tiny 8051-subset core booted over an 8N1 UART. Code is loaded byte-by-byte after reset,
// then executed from address 0. Define ICE51_MUL_EN to add register B, MOV A,B / MOV B,A and MUL AB.
module ice51_top #(
    parameter int unsigned MEM_SIZE = 512,
    parameter int unsigned BAUD_DIV = 104
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_uart_rx,
    output logic o_uart_tx
);
    localparam int unsigned CW = $clog2(BAUD_DIV + 1);
    localparam int unsigned AW = $clog2(MEM_SIZE);
    localparam logic [CW-1:0] BitLast  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HalfLast = CW'(BAUD_DIV / 2 - 1);
    localparam logic [8:0] LastAddr = 9'(MEM_SIZE - 1);
    localparam logic signed [10:0] MemSizeS = 11'(MEM_SIZE);

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e     rx_state_q, rx_state_d;
    logic [2:0]    rx_sync_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid, rx_in, rx_fall;

    assign rx_in   = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_sync_q  <= 3'b111;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[1:0], i_uart_rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = RxStart;
            end
            RxStart: begin
                // A start bit that is high again at its centre was a glitch.
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_in ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_in, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_valid   = 1'b1;
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------- UART transmitter ----------------
    logic          tx_busy_q;
    logic [9:0]    tx_shift_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic          tx_start;
    logic [7:0]    tx_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else if (tx_start) begin
            tx_busy_q  <= 1'b1;
            tx_shift_q <= {1'b1, tx_data, 1'b0};
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BitLast) begin
                tx_cnt_q   <= '0;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
                else tx_bit_q <= tx_bit_q + 4'd1;
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    assign o_uart_tx = ~tx_busy_q | tx_shift_q[0];

    // ---------------- code memory ----------------
    logic [7:0] mem [MEM_SIZE];
    logic       mem_we;
    logic [7:0] mem_rd;
    logic [8:0] load_addr_q, load_addr_d;
    logic [8:0] pc_q, pc_d;

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[load_addr_q[AW-1:0]] <= rx_shift_q;
    end

    assign mem_rd = mem[pc_q[AW-1:0]];

    // ---------------- core ----------------
    typedef enum logic [1:0] {StLoad, StFetch0, StFetch1, StExec} core_state_e;

    core_state_e state_q, state_d;
    logic [7:0]  op_q, op_d, arg_q, arg_d, a_q, a_d;
    logic        c_q, c_d;
    logic [7:0]  r_q [8];
    logic [7:0]  r_d [8];
`ifdef ICE51_MUL_EN
    logic [7:0]  b_q, b_d;
`endif

    logic [2:0]        rn;
    logic [8:0]        pc_inc, br_target, add_res;
    logic [7:0]        djnz_res;
    logic signed [10:0] br_sum, br_wrap;

    function automatic logic two_byte(input logic [7:0] op);
        return (op inside {8'h74, 8'h24, 8'h80, 8'h60, 8'h70, 8'hF5, 8'hE5}) ||
               (op[7:3] inside {5'b01111, 5'b11011});
    endfunction

    assign rn       = op_q[2:0];
    assign pc_inc   = (pc_q == LastAddr) ? 9'd0 : pc_q + 9'd1;
    assign add_res  = {1'b0, a_q} + {1'b0, (op_q[3] ? r_q[rn] : arg_q)};
    assign djnz_res = r_q[rn] - 8'd1;
    // Relative target taken modulo MEM_SIZE from the already-advanced PC.
    assign br_sum    = $signed({2'b00, pc_q}) + $signed({{3{arg_q[7]}}, arg_q});
    assign br_wrap   = (br_sum < 11'sd0) ? br_sum + MemSizeS :
                       (br_sum >= MemSizeS) ? br_sum - MemSizeS : br_sum;
    assign br_target = 9'(br_wrap);
    assign tx_data   = a_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StLoad;
            load_addr_q <= '0;
            pc_q        <= '0;
            op_q        <= '0;
            arg_q       <= '0;
            a_q         <= '0;
            c_q         <= 1'b0;
            r_q         <= '{default: '0};
`ifdef ICE51_MUL_EN
            b_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            pc_q        <= pc_d;
            op_q        <= op_d;
            arg_q       <= arg_d;
            a_q         <= a_d;
            c_q         <= c_d;
            r_q         <= r_d;
`ifdef ICE51_MUL_EN
            b_q         <= b_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        pc_d        = pc_q;
        op_d        = op_q;
        arg_d       = arg_q;
        a_d         = a_q;
        c_d         = c_q;
        r_d         = r_q;
`ifdef ICE51_MUL_EN
        b_d         = b_q;
`endif
        mem_we      = 1'b0;
        tx_start    = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (rx_valid) begin
                    mem_we = 1'b1;
                    if (load_addr_q == LastAddr) begin
                        state_d = StFetch0;
                        pc_d    = '0;
                    end else begin
                        load_addr_d = load_addr_q + 9'd1;
                    end
                end
            end
            StFetch0: begin
                op_d    = mem_rd;
                pc_d    = pc_inc;
                state_d = two_byte(mem_rd) ? StFetch1 : StExec;
            end
            StFetch1: begin
                arg_d   = mem_rd;
                pc_d    = pc_inc;
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch0;
                unique casez (op_q)
                    8'h74:       a_d = arg_q;
                    8'b11101???: a_d = r_q[rn];
                    8'b11111???: r_d[rn] = a_q;
                    8'b01111???: r_d[rn] = arg_q;
                    8'h24, 8'b00101???: {c_d, a_d} = add_res;
                    8'h04:       a_d = a_q + 8'd1;
                    8'h14:       a_d = a_q - 8'd1;
                    8'b00001???: r_d[rn] = r_q[rn] + 8'd1;
                    8'h80:       pc_d = br_target;
                    8'h60:       if (a_q == 8'd0) pc_d = br_target;
                    8'h70:       if (a_q != 8'd0) pc_d = br_target;
                    8'b11011???: begin
                        r_d[rn] = djnz_res;
                        if (djnz_res != 8'd0) pc_d = br_target;
                    end
                    8'hF5: begin
                        if (arg_q == 8'h99) begin
                            // Hold in execute until the previous frame has left the wire.
                            if (tx_busy_q) state_d = StExec;
                            else tx_start = 1'b1;
                        end
`ifdef ICE51_MUL_EN
                        else if (arg_q == 8'hF0) b_d = a_q;
`endif
                    end
`ifdef ICE51_MUL_EN
                    8'hE5: if (arg_q == 8'hF0) a_d = b_q;
                    8'hA4: begin
                        {b_d, a_d} = a_q * b_q;
                        c_d        = 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
            default: state_d = StLoad;
        endcase
    end
endmodule

// File: tb/tb_ice51_top.sv
// Bench for ice51_top: programs are loaded over UART, an ISA-level model predicts the TX bytes
// and a UART monitor decodes o_uart_tx and checks each frame against the expected-byte queue.
`timescale 1ns/1ps
module tb_ice51_top;
    localparam int M  = 104;
    localparam int BD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    ice51_top #(.MEM_SIZE(M), .BAUD_DIV(BD)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_uart_rx(rx),
        .o_uart_tx(tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] img [M];
    logic [7:0] prog[$];
    logic [7:0] exp_a;
    logic       exp_c;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         mon_busy = 1'b0;
    int         mon_cnt  = 0;
    int         mon_bits = 0;
    logic       prev_tx  = 1'b1;
    logic [9:0] mon_frame;

    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (prev_tx === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                mon_bits = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= BD / 2 && (mon_cnt - BD / 2) % BD == 0) begin
                mon_frame = {tx, mon_frame[9:1]};
                mon_bits++;
                if (mon_bits == 10) begin
                    mon_busy = 1'b0;
                    check("tx_frame_start_stop", int'({mon_frame[9], mon_frame[0]}), 2);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected_byte: got 0x%0h, expected no byte",
                                 mon_frame[8:1]);
                    end else begin
                        check("tx_byte", int'(mon_frame[8:1]), int'(exp_q.pop_front()));
                    end
                end
            end
        end
        prev_tx = tx;
    end

    // ---------------- reference model ----------------
    task automatic run_model();
        int pc = 0;
        int nxt, rel, tgt, len, s, prod;
        logic [7:0] op, arg, a, b;
        logic [2:0] n;
        logic c;
        logic [7:0] r [8];
        a = 0; b = 0; c = 0;
        for (int i = 0; i < 8; i++) r[i] = 0;
        for (int step = 0; step < 20000; step++) begin
            op  = img[pc];
            arg = img[(pc + 1) % M];
            n   = op[2:0];
            len = (op inside {8'h74, 8'h24, 8'h80, 8'h60, 8'h70, 8'hF5, 8'hE5,
                              [8'h78:8'h7F], [8'hD8:8'hDF]}) ? 2 : 1;
            nxt = (pc + len) % M;
            rel = arg[7] ? int'(arg) - 256 : int'(arg);
            tgt = ((nxt + rel) % M + M) % M;
            if (op == 8'h80 && arg == 8'hFE) break;
            case (op) inside
                8'h74:          a = arg;
                [8'hE8:8'hEF]:  a = r[n];
                [8'hF8:8'hFF]:  r[n] = a;
                [8'h78:8'h7F]:  r[n] = arg;
                8'h24:          begin s = int'(a) + int'(arg); c = (s > 255); a = 8'(s); end
                [8'h28:8'h2F]:  begin s = int'(a) + int'(r[n]); c = (s > 255); a = 8'(s); end
                8'h04:          a = a + 8'd1;
                8'h14:          a = a - 8'd1;
                [8'h08:8'h0F]:  r[n] = r[n] + 8'd1;
                8'h80:          nxt = tgt;
                8'h60:          if (a == 0) nxt = tgt;
                8'h70:          if (a != 0) nxt = tgt;
                [8'hD8:8'hDF]:  begin r[n] = r[n] - 8'd1; if (r[n] != 0) nxt = tgt; end
                8'hF5: begin
                    if (arg == 8'h99) exp_q.push_back(a);
`ifdef ICE51_MUL_EN
                    else if (arg == 8'hF0) b = a;
`endif
                end
`ifdef ICE51_MUL_EN
                8'hE5:          if (arg == 8'hF0) a = b;
                8'hA4:          begin prod = int'(a) * int'(b); a = 8'(prod); b = 8'(prod >> 8); c = 0; end
`endif
                default: ;
            endcase
            pc = nxt;
        end
        exp_a = a;
        exp_c = c;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] bv);
        logic [9:0] fr;
        fr = {1'b1, bv, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[0];
            fr = fr >> 1;
            repeat (BD) @(posedge clk);
            #1;
        end
    endtask

    task automatic load_image(input bit glitch);
        if (glitch) begin
            rx = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rx = 1'b1;
            repeat (2 * BD) @(posedge clk);
            #1;
        end
        for (int i = 0; i < M; i++) send_byte(img[i]);
    endtask

    task automatic set_prog();
        for (int i = 0; i < M; i++) img[i] = (i < prog.size()) ? prog[i] : 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic gen_random();
        int p = 0;
        int kind;
        logic [7:0] imm, und;
        logic [2:0] n;
        logic [7:0] undef_ops [4];
        undef_ops = '{8'hA5, 8'h01, 8'h33, 8'hC3};
        for (int i = 0; i < M; i++) img[i] = 8'h00;
        while (p < M - 12) begin
            kind = $urandom_range(0, 13);
            n    = 3'($urandom);
            imm  = 8'($urandom);
            und  = undef_ops[$urandom_range(0, 3)];
            case (kind)
                0:  begin img[p] = 8'h00; p += 1; end
                1:  begin img[p] = 8'h74; img[p+1] = imm; p += 2; end
                2:  begin img[p] = {5'b11101, n}; p += 1; end
                3:  begin img[p] = {5'b11111, n}; p += 1; end
                4:  begin img[p] = {5'b01111, n}; img[p+1] = imm; p += 2; end
                5:  begin img[p] = 8'h24; img[p+1] = imm; p += 2; end
                6:  begin img[p] = {5'b00101, n}; p += 1; end
                7:  begin img[p] = 8'h04; p += 1; end
                8:  begin img[p] = 8'h14; p += 1; end
                9:  begin img[p] = {5'b00001, n}; p += 1; end
                10, 13: begin img[p] = 8'hF5; img[p+1] = 8'h99; p += 2; end
                11: begin img[p] = und; p += 1; end
                default: begin
                    img[p] = imm[0] ? 8'h60 : 8'h70; img[p+1] = 8'h01; img[p+2] = 8'h04; p += 3;
                end
            endcase
        end
        img[p]   = 8'h80;
        img[p+1] = 8'hFE;
    endtask

    task automatic finish_program(input string name);
        int waited = 0;
        int lows   = 0;
        while (exp_q.size() != 0 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_pending_bytes"}, exp_q.size(), 0);
        for (int i = 0; i < 30 * BD; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check({name, "_tx_low_after_end"}, lows, 0);
        check({name, "_acc"}, int'(dut.a_q), int'(exp_a));
        check({name, "_carry"}, int'(dut.c_q), int'(exp_c));
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_acc", int'(dut.a_q), 0);
        check("reset_carry", int'(dut.c_q), 0);
        check("reset_pc", int'(dut.pc_q), 0);
        rst = 1'b0;

        prog = '{8'h74, 8'h55, 8'hF5, 8'h99, 8'h80, 8'hFE};
        set_prog(); run_model(); load_image(1'b0); finish_program("single_byte");
        // Bytes arriving in RUN must not disturb the core.
        send_byte(8'h74); send_byte(8'hF5); send_byte(8'h99);
        repeat (10 * BD) @(negedge clk);
        check("run_rx_ignored_acc", int'(dut.a_q), int'(exp_a));

        do_reset();
        prog = '{8'h74, 8'hFF, 8'h24, 8'h02, 8'hF5, 8'h99, 8'h80, 8'hFE};
        set_prog(); run_model(); load_image(1'b1); finish_program("add_carry");

        do_reset();
        prog = '{8'h74, 8'h00, 8'h78, 8'h03, 8'h74, 8'h41, 8'hF5, 8'h99, 8'h04, 8'hD8, 8'hFB, 8'h80, 8'hFE};
        prog = prog[2:$];
        set_prog(); run_model(); load_image(1'b0); finish_program("djnz_loop");

        do_reset();
        prog = '{8'h74, 8'h10, 8'hF5, 8'hF0, 8'h74, 8'h11, 8'hA4, 8'hF5, 8'h99,
                 8'hE5, 8'hF0, 8'hF5, 8'h99, 8'h80, 8'hFE};
        set_prog(); run_model(); load_image(1'b0); finish_program("mul_option");

        // Reset in the middle of a TX frame.
        do_reset();
        prog = '{8'h74, 8'hA5, 8'hF5, 8'h99, 8'h80, 8'hFE};
        set_prog(); run_model(); load_image(1'b0);
        seen = 0;
        for (int i = 0; i < 20000 && seen == 0; i++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1;
        end
        check("midtx_frame_started", seen, 1);
        repeat (3 * BD) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midtx_reset_tx", int'(tx), 1);
        check("midtx_reset_acc", int'(dut.a_q), 0);
        rst = 1'b0;
        exp_q.delete();

        // Reset after byte 100 of a load, then a full reload.
        gen_random();
        for (int i = 0; i <= 100; i++) send_byte(img[i]);
        do_reset();
        gen_random(); run_model(); load_image(1'b0); finish_program("reload_random");

        do_reset();
        gen_random(); run_model(); load_image(1'b0); finish_program("random2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
